// File: rtl/fpu_seq_divider.sv
// Sequential unsigned restoring divider for the FPU mantissa path: one quotient bit per clock.
// Optional sticky output enabled by defining FPU_DIV_STICKY_EN.
module fpu_seq_divider #(
    parameter int unsigned WIDTH = 48,
    parameter int unsigned QW    = 25
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [QW-1:0]    quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             q_ovf,
`ifdef FPU_DIV_STICKY_EN
    output logic             sticky,
`endif
    output logic             div_zero
);

    localparam int unsigned CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_ZERO,
        S_FIN
    } state_t;

    state_t           state;
    logic [WIDTH:0]   p;
    logic [WIDTH-1:0] s;
    logic [WIDTH-1:0] div_r;
    logic [CW-1:0]    cnt;

    logic [WIDTH:0]   p_shift;
    logic [WIDTH+1:0] trial;
    logic [WIDTH:0]   p_next;
    logic [WIDTH-1:0] s_next;
    logic [WIDTH-1:0] s_hi;

    // The partial remainder never exceeds the divisor, so its top bit stays clear
    // and only the low WIDTH bits feed the next shift.
    logic unused_p_msb;
    assign unused_p_msb = p[WIDTH];

    always_comb begin
        p_shift = {p[WIDTH-1:0], s[WIDTH-1]};
        trial   = {1'b0, p_shift} - {2'b00, div_r};
        if (!trial[WIDTH+1]) begin
            p_next = trial[WIDTH:0];
            s_next = {s[WIDTH-2:0], 1'b1};
        end else begin
            p_next = p_shift;
            s_next = {s[WIDTH-2:0], 1'b0};
        end
        // Quotient bits that do not fit in the output; empty when QW == WIDTH.
        s_hi = s_next >> QW;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            p         <= '0;
            s         <= '0;
            div_r     <= '0;
            cnt       <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            quotient  <= '0;
            remainder <= '0;
            q_ovf     <= 1'b0;
            div_zero  <= 1'b0;
`ifdef FPU_DIV_STICKY_EN
            sticky    <= 1'b0;
`endif
        end else begin
            case (state)
                S_IDLE, S_FIN: begin
                    if (start) begin
                        div_r    <= divisor;
                        p        <= '0;
                        s        <= dividend;
                        cnt      <= CW'(WIDTH);
                        done     <= 1'b0;
                        q_ovf    <= 1'b0;
                        div_zero <= 1'b0;
`ifdef FPU_DIV_STICKY_EN
                        sticky   <= 1'b0;
`endif
                        if (divisor == '0) begin
                            state <= S_ZERO;
                        end else begin
                            state <= S_RUN;
                            busy  <= 1'b1;
                        end
                    end
                end
                S_RUN: begin
                    p   <= p_next;
                    s   <= s_next;
                    cnt <= cnt - CW'(1);
                    if (cnt == CW'(1)) begin
                        state     <= S_FIN;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        quotient  <= s_next[QW-1:0];
                        remainder <= p_next[WIDTH-1:0];
                        q_ovf     <= |s_hi;
`ifdef FPU_DIV_STICKY_EN
                        sticky    <= |p_next[WIDTH-1:0];
`endif
                    end
                end
                S_ZERO: begin
                    // Captured dividend is still in s: it becomes the remainder.
                    state     <= S_FIN;
                    done      <= 1'b1;
                    div_zero  <= 1'b1;
                    quotient  <= '1;
                    remainder <= s;
                    cnt       <= '0;
`ifdef FPU_DIV_STICKY_EN
                    sticky    <= |s;
`endif
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: doc/fpu_seq_divider.md
Name: fpu_seq_divider

Overview:
- Parametrised sequential unsigned integer divider for the FPU mantissa-divide path. It generalises the fixed 48-bit shift-subtract divider.
- Produces one quotient bit per clock and returns both a quotient and a true remainder.
- Adds an explicit start/busy/done handshake, divide-by-zero handling, quotient-overflow detection and asynchronous reset.
- Sits between the FPU operand-alignment stage and the normalise/round stage.

Parameters:
- WIDTH, 48: dividend/divisor/remainder width in bits; also the iteration count. Minimum 2.
- QW, 25: quotient output width. Must satisfy 1 <= QW <= WIDTH. Upper WIDTH-QW quotient bits are checked for overflow, not output.

Ports:
- clk  input  1  clock; all state changes on posedge.
- rst  input  1  asynchronous active-high reset.
- start  input  1  request; sampled on posedge only when the unit is not busy.
- dividend  input  WIDTH  unsigned dividend; captured at the start-accept edge only.
- divisor  input  WIDTH  unsigned divisor; captured at the start-accept edge only.
- busy  output  1  high while iterating.
- done  output  1  high while the result is valid; held until the next accepted start.
- quotient  output  QW  low QW bits of floor(dividend/divisor).
- remainder  output  WIDTH  dividend mod divisor.
- q_ovf  output  1  at least one quotient bit above QW-1 is set.
- div_zero  output  1  divisor was zero.

Behaviour:
- Reset (async, any time, including mid-operation):
  - State goes to IDLE.
  - busy=0, done=0, quotient=0, remainder=0, q_ovf=0, div_zero=0.
  - Iteration counter and datapath registers are cleared.
- States:
  - IDLE -> LOAD-accept on start=1.
  - RUN: WIDTH cycles.
  - DONE: holds the result.
  - start is accepted in IDLE or DONE. start is ignored in RUN; no queuing.
- Accept edge E0 (start=1, not busy):
  - Operands are captured.
  - Partial remainder P (WIDTH+1 bits) is cleared to 0. Shift register S is loaded with the dividend.
  - Counter is set to WIDTH.
  - done, q_ovf and div_zero clear at E0.
  - busy=1 after E0 if divisor!=0.
- Iteration at each RUN edge:
  - Shift {P,S} left by 1.
  - Form trial T = P_shifted - {1'b0,divisor} at WIDTH+2 bits.
  - If T is non-negative: P=T and S[0]=1. Otherwise P is kept and S[0]=0.
  - Counter decrements by 1.
- Completion:
  - At edge E_WIDTH the last iteration completes. After that edge: busy=0, done=1.
  - quotient=S[QW-1:0], remainder=P[WIDTH-1:0], q_ovf=|S[WIDTH-1:QW] (0 when QW==WIDTH).
  - Latency: done rises exactly WIDTH cycles after E0.
- Outputs in DONE:
  - Stable until the next accept edge or reset.
  - quotient and remainder show the previous result while RUN is active. Consumers use done only.
- Divide by zero:
  - Detected at E0. RUN is skipped.
  - After E1: done=1, busy=0, div_zero=1, quotient=all ones, remainder=dividend, q_ovf=0.
- Back-to-back operation: start=1 in the same cycle done=1 is accepted. done drops after that edge. No idle cycle is needed between operations.
- dividend=0 with divisor!=0: the full WIDTH cycles are still taken. Result is quotient=0, remainder=0.
- Operand changes after E0 have no effect on the result.

Optional Feature:
- Macro: FPU_DIV_STICKY_EN.
- Defined:
  - Adds output port sticky (1 bit) = |remainder, registered with the result.
  - Reset value 0; cleared at the accept edge.
  - Forced to 1 on div_zero when dividend!=0, else 0.
  - Used by the rounding stage as the inexact/sticky bit.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
1. WIDTH=8, QW=8: dividend=200, divisor=7, start for 1 cycle -> done after exactly 8 cycles; quotient=28, remainder=4, q_ovf=0, div_zero=0, sticky=1 if enabled.
2. WIDTH=8, QW=4: 200/7 -> quotient=12 (28 mod 16), remainder=4, q_ovf=1.
3. WIDTH=8: dividend=55, divisor=0 -> done one cycle after accept; quotient=8'hFF truncated to QW, remainder=55, div_zero=1, busy never high.
4. WIDTH=48, QW=25: dividend=48'h91EC91000000, divisor=48'h000000EC0000 -> quotient=low 25 bits of floor(N/D), remainder=N mod D, matching the bench reference model; done at cycle 48.
5. Issue a second start during RUN cycle 3 with different operands -> ignored; first result is unaffected. Start asserted while done=1 with 100/10 -> accepted, done drops, then quotient=10, remainder=0.
6. Assert rst asynchronously mid-RUN (cycle 4) -> all outputs 0 immediately, without waiting for a clock edge. After release, a new 9/3 start completes normally with quotient=3, remainder=0.
